// File: rtl/parse_class_egr_intf.sv
// Egress stage: pairs classifier results with packet beats from the align FIFO.
// Forwarded packets leave on an AXI-S master; dropped packets are drained.
package packet_switch_pkg;
   localparam int EGR_PORT_W = 4;
   localparam int BYTESVLD_W = 7;

   typedef struct packed {
      logic                  sop;
      logic                  eop;
      logic [BYTESVLD_W-1:0] bytesvld;
      logic [EGR_PORT_W-1:0] egr_port;
   } SEGMENT_INFO_S;
endpackage

module parse_class_egr_intf
   import packet_switch_pkg::*;
#(
   parameter int TDATA_WIDTH        = 512,
   parameter int USERMETADATA_WIDTH = 1,
   parameter int SEGMENT_WIDTH      = 128,
   parameter int SEGMENT_DEPTH      = TDATA_WIDTH/SEGMENT_WIDTH,
   parameter int RES_FIFO_DEPTH     = 16,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     res_vld,
   input  logic [EGR_PORT_W-1:0]                    res_egr_port,
   input  logic                                     res_drop,
   output logic                                     res_fifo_full,
   input  logic [SEGMENT_DEPTH-1:0][SEGMENT_WIDTH-1:0] aln_fifo_tdata,
   input  logic [USERMETADATA_WIDTH-1:0]            aln_fifo_tuser_usermetadata,
   input  SEGMENT_INFO_S                            aln_fifo_tuser_segment_info,
   input  logic                                     aln_fifo_empty,
   output logic                                     aln_fifo_pop,
   output logic                                     tvalid,
   input  logic                                     tready,
   output logic [SEGMENT_DEPTH-1:0][SEGMENT_WIDTH-1:0] tdata,
   output logic [TDATA_WIDTH/8-1:0]                 tkeep,
   output logic [USERMETADATA_WIDTH-1:0]            tuser_usermetadata,
   output SEGMENT_INFO_S                            tuser_segment_info,
   output logic [CNT_WIDTH-1:0]                     pkt_fwd_cnt,
   output logic [CNT_WIDTH-1:0]                     pkt_drop_cnt,
   output logic                                     res_overflow,
   output logic                                     proto_err,
   output logic [1:0]                               dbg_state
);

   localparam int              KEEP_W   = TDATA_WIDTH/8;
   localparam int              PTR_W    = $clog2(RES_FIFO_DEPTH);
   localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(RES_FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FWD  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   // Result FIFO entry layout: {egr_port, drop}
   logic [EGR_PORT_W:0]   r_res_mem [RES_FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W:0]        r_res_cnt;
   logic                  r_res_full;
   logic                  r_res_overflow;

   logic [1:0]            r_state;
   logic [EGR_PORT_W-1:0] r_cur_egr_port;
   logic                  r_first;

   logic                                     r_tvalid;
   logic [SEGMENT_DEPTH-1:0][SEGMENT_WIDTH-1:0] r_tdata;
   logic [KEEP_W-1:0]                        r_tkeep;
   logic [USERMETADATA_WIDTH-1:0]            r_tuser_meta;
   SEGMENT_INFO_S                            r_tuser_seg;
   logic [CNT_WIDTH-1:0]                     r_fwd_cnt;
   logic [CNT_WIDTH-1:0]                     r_drop_cnt;
   logic                                     r_proto_err;

   logic [EGR_PORT_W:0]   w_res_head;
   logic                  w_res_pop;
   logic                  w_res_wr;
   logic [PTR_W:0]        w_res_cnt_nxt;
   logic                  w_aln_pop;
   logic                  w_load;
   logic [KEEP_W-1:0]     w_tkeep;
   SEGMENT_INFO_S         w_seg_out;

   assign w_res_head = r_res_mem[r_rd_ptr];
   assign w_res_pop  = (r_state == ST_IDLE) && (r_res_cnt != '0) && !aln_fifo_empty;
   // A pop in the same cycle frees a slot, so a write on a full FIFO still lands.
   assign w_res_wr   = res_vld && (!r_res_full || w_res_pop);

   always_comb begin
      w_res_cnt_nxt = r_res_cnt;
      if (w_res_wr && !w_res_pop)
         w_res_cnt_nxt = r_res_cnt + 1'b1;
      else if (!w_res_wr && w_res_pop)
         w_res_cnt_nxt = r_res_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_res_wr)
         r_res_mem[r_wr_ptr] <= {res_egr_port, res_drop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_res_cnt      <= '0;
         r_res_full     <= 1'b0;
         r_res_overflow <= 1'b0;
      end else begin
         if (w_res_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_res_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_res_cnt  <= w_res_cnt_nxt;
         r_res_full <= (w_res_cnt_nxt == FULL_CNT);
         if (res_vld && !w_res_wr)
            r_res_overflow <= 1'b1;
      end
   end

   // Output handshake: a beat transfers when tvalid & tready; while tvalid is high
   // without tready every output holds. DROP pops regardless of tready.
   always_comb begin
      w_aln_pop = 1'b0;
      case (r_state)
         ST_FWD:  w_aln_pop = !aln_fifo_empty && (!r_tvalid || tready);
         ST_DROP: w_aln_pop = !aln_fifo_empty;
         default: w_aln_pop = 1'b0;
      endcase
   end

   assign w_load = (r_state == ST_FWD) && w_aln_pop;

   always_comb begin
      w_tkeep = '0;
      for (int i = 0; i < KEEP_W; i++)
         w_tkeep[i] = (i < 32'(aln_fifo_tuser_segment_info.bytesvld));
   end

   always_comb begin
      w_seg_out          = aln_fifo_tuser_segment_info;
      w_seg_out.egr_port = r_cur_egr_port;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_cur_egr_port <= '0;
         r_first        <= 1'b0;
         r_tvalid       <= 1'b0;
         r_tdata        <= '0;
         r_tkeep        <= '0;
         r_tuser_meta   <= '0;
         r_tuser_seg    <= '0;
         r_fwd_cnt      <= '0;
         r_drop_cnt     <= '0;
         r_proto_err    <= 1'b0;
      end else begin
         if (w_load) begin
            r_tvalid     <= 1'b1;
            r_tdata      <= aln_fifo_tdata;
            r_tkeep      <= w_tkeep;
            r_tuser_meta <= aln_fifo_tuser_usermetadata;
            r_tuser_seg  <= w_seg_out;
         end else if (tready) begin
            r_tvalid <= 1'b0;
         end

         if (w_aln_pop) begin
            r_first <= 1'b0;
            if (aln_fifo_tuser_segment_info.sop && !r_first)
               r_proto_err <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_res_pop) begin
                  r_cur_egr_port <= w_res_head[EGR_PORT_W:1];
                  r_first        <= 1'b1;
                  r_state        <= w_res_head[0] ? ST_DROP : ST_FWD;
               end
            end
            ST_FWD: begin
               if (w_aln_pop && aln_fifo_tuser_segment_info.eop) begin
                  r_fwd_cnt <= r_fwd_cnt + 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (w_aln_pop && aln_fifo_tuser_segment_info.eop) begin
                  r_drop_cnt <= r_drop_cnt + 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign res_fifo_full      = r_res_full;
   assign res_overflow       = r_res_overflow;
   assign aln_fifo_pop       = w_aln_pop;
   assign tvalid             = r_tvalid;
   assign tdata              = r_tdata;
   assign tkeep              = r_tkeep;
   assign tuser_usermetadata = r_tuser_meta;
   assign tuser_segment_info = r_tuser_seg;
   assign pkt_fwd_cnt        = r_fwd_cnt;
   assign pkt_drop_cnt       = r_drop_cnt;
   assign proto_err          = r_proto_err;
   assign dbg_state          = r_state;

endmodule

// File: tb/tb_parse_class_egr_intf.sv
// Randomized scoreboard bench for parse_class_egr_intf: packets and results are
// modelled as whole objects; a monitor pops the expected beat queue on each transfer.
module tb_parse_class_egr_intf;
   import packet_switch_pkg::*;

   localparam int TW  = 512;
   localparam int SW  = 128;
   localparam int SD  = TW/SW;
   localparam int KW  = TW/8;
   localparam int MW  = 1;
   localparam int SIW = $bits(SEGMENT_INFO_S);
   localparam int EW  = TW + KW + MW + SIW;
   localparam int CW  = 32;

   logic                     clk;
   logic                     rst_n;
   logic                     res_vld;
   logic [EGR_PORT_W-1:0]    res_egr_port;
   logic                     res_drop;
   logic                     res_fifo_full;
   logic [SD-1:0][SW-1:0]    aln_fifo_tdata;
   logic [MW-1:0]            aln_fifo_tuser_usermetadata;
   SEGMENT_INFO_S            aln_fifo_tuser_segment_info;
   logic                     aln_fifo_empty;
   logic                     aln_fifo_pop;
   logic                     tvalid;
   logic                     tready;
   logic [SD-1:0][SW-1:0]    tdata;
   logic [KW-1:0]            tkeep;
   logic [MW-1:0]            tuser_usermetadata;
   SEGMENT_INFO_S            tuser_segment_info;
   logic [CW-1:0]            pkt_fwd_cnt;
   logic [CW-1:0]            pkt_drop_cnt;
   logic                     res_overflow;
   logic                     proto_err;
   logic [1:0]               dbg_state;

   parse_class_egr_intf dut (
      .clk(clk), .rst_n(rst_n),
      .res_vld(res_vld), .res_egr_port(res_egr_port), .res_drop(res_drop),
      .res_fifo_full(res_fifo_full),
      .aln_fifo_tdata(aln_fifo_tdata),
      .aln_fifo_tuser_usermetadata(aln_fifo_tuser_usermetadata),
      .aln_fifo_tuser_segment_info(aln_fifo_tuser_segment_info),
      .aln_fifo_empty(aln_fifo_empty), .aln_fifo_pop(aln_fifo_pop),
      .tvalid(tvalid), .tready(tready), .tdata(tdata), .tkeep(tkeep),
      .tuser_usermetadata(tuser_usermetadata), .tuser_segment_info(tuser_segment_info),
      .pkt_fwd_cnt(pkt_fwd_cnt), .pkt_drop_cnt(pkt_drop_cnt),
      .res_overflow(res_overflow), .proto_err(proto_err), .dbg_state(dbg_state)
   );

   typedef struct packed {
      logic [TW-1:0] data;
      logic [MW-1:0] meta;
      SEGMENT_INFO_S si;
   } beat_t;

   beat_t         aln_q[$];
   logic [EW-1:0] exp_q[$];

   int n_cmp = 0;
   int n_fail = 0;
   int n_pops = 0;
   int mon_cnt = 0;
   int exp_fwd = 0;
   int exp_drop = 0;
   int tr_mode = 0;
   bit gap_en = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input logic [EW:0] act, input logic [EW:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [KW-1:0] ref_keep(input int bv);
      if (bv >= KW) return {KW{1'b1}};
      return (64'd1 << bv) - 64'd1;
   endfunction

   // One clock of the upstream align FIFO model plus tready driving.
   task automatic tick();
      logic pop_s;
      case (tr_mode)
         0:       tready = 1'b1;
         1:       tready = !tready;
         2:       tready = ($urandom_range(0, 2) != 0);
         default: tready = 1'b0;
      endcase
      if (aln_q.size() != 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
         aln_fifo_empty              = 1'b0;
         aln_fifo_tdata              = aln_q[0].data;
         aln_fifo_tuser_usermetadata = aln_q[0].meta;
         aln_fifo_tuser_segment_info = aln_q[0].si;
      end else begin
         aln_fifo_empty              = 1'b1;
         aln_fifo_tdata              = '0;
         aln_fifo_tuser_usermetadata = '0;
         aln_fifo_tuser_segment_info = '0;
      end
      #1;
      pop_s = aln_fifo_pop;
      if (pop_s) chk("pop_while_empty", 64'(aln_fifo_empty), 64'd0);
      @(posedge clk);
      if (pop_s && aln_q.size() != 0) begin
         aln_q.delete(0);
         n_pops++;
      end
      @(negedge clk);
   endtask

   task automatic issue_res(input logic [EGR_PORT_W-1:0] egr, input bit drop);
      res_vld      = 1'b1;
      res_egr_port = egr;
      res_drop     = drop;
      tick();
      res_vld      = 1'b0;
   endtask

   task automatic push_pkt(input logic [EGR_PORT_W-1:0] egr, input bit drop, input int nb,
                           input int last_bv, input int sop_mid, input bit with_res);
      for (int b = 0; b < nb; b++) begin
         beat_t         bt;
         SEGMENT_INFO_S so;
         for (int k = 0; k < TW/32; k++) bt.data[k*32 +: 32] = $urandom();
         bt.meta        = MW'($urandom_range(0, 1));
         bt.si.sop      = (b == 0) || (b == sop_mid);
         bt.si.eop      = (b == nb - 1);
         bt.si.bytesvld = BYTESVLD_W'((b == nb - 1) ? last_bv : KW);
         bt.si.egr_port = EGR_PORT_W'($urandom_range(0, 15));
         aln_q.push_back(bt);
         if (!drop) begin
            so          = bt.si;
            so.egr_port = egr;
            exp_q.push_back({bt.data, ref_keep(int'(bt.si.bytesvld)), bt.meta, so});
         end
      end
      if (drop) exp_drop++;
      else      exp_fwd++;
      if (with_res) issue_res(egr, drop);
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || aln_q.size() != 0 || dbg_state != 2'd0 || tvalid) && k < 3000) begin
         tick();
         k++;
      end
      chk("drain_within_budget", 64'(k < 3000), 64'd1);
   endtask

   // monitor / scoreboard
   initial begin
      logic [EW:0] prev_val;
      logic [EW:0] cur;
      bit          prev_stall;
      prev_stall = 0;
      prev_val   = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            prev_stall = 0;
         end else begin
            cur = {tvalid, tdata, tkeep, tuser_usermetadata, tuser_segment_info};
            if (prev_stall) chk_vec("hold_while_stalled", cur, prev_val);
            if (tvalid && tready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", 64'd1, 64'd0);
               end else begin
                  chk_vec("beat", {1'b0, cur[EW-1:0]}, {1'b0, exp_q.pop_front()});
               end
               mon_cnt++;
            end
            prev_stall = tvalid && !tready;
            prev_val   = cur;
         end
      end
   end

   initial begin
      int base;
      int k;
      rst_n = 1'b0;  res_vld = 1'b0;  res_egr_port = '0;  res_drop = 1'b0;
      tready = 1'b0; aln_fifo_empty = 1'b1; aln_fifo_tdata = '0;
      aln_fifo_tuser_usermetadata = '0; aln_fifo_tuser_segment_info = '0;
      repeat (2) @(negedge clk);
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk_vec("rst_tdata", {1'b0, tdata, tkeep, tuser_usermetadata, tuser_segment_info}, '0);
      chk("rst_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
      chk("rst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
      chk("rst_flags", {61'd0, res_overflow, proto_err, res_fifo_full}, 64'd0);
      rst_n = 1'b1;
      tick();

      // single-beat forward with latency check
      tr_mode = 3; gap_en = 0;
      push_pkt(4'd3, 1'b0, 1, 60, -1, 1'b1);
      tick();
      chk("lat_tvalid_n2", 64'(tvalid), 64'd0);
      tick();
      chk("lat_tvalid_n3", 64'(tvalid), 64'd1);
      chk("single_egr_port", 64'(tuser_segment_info.egr_port), 64'd3);
      chk("single_tkeep", tkeep, 64'h0FFF_FFFF_FFFF_FFFF);
      tr_mode = 0;
      drain();
      chk("single_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

      // two 4-beat packets with tready toggling
      tr_mode = 1;
      push_pkt(4'd5, 1'b0, 4, 17, -1, 1'b1);
      push_pkt(4'd9, 1'b0, 4, 64, -1, 1'b1);
      drain();
      chk("b2b_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

      // drop with tready held low, then a forward packet waits at the output
      tr_mode = 3;
      base = n_pops;
      push_pkt(4'd1, 1'b1, 3, 10, -1, 1'b1);
      push_pkt(4'd7, 1'b0, 2, 33, -1, 1'b1);
      repeat (12) tick();
      chk("drop_pops", 64'(n_pops - base), 64'd4);
      chk("drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));
      chk("drop_next_waiting", 64'(tvalid), 64'd1);
      chk_vec("drop_next_head", {1'b0, tdata, tkeep, tuser_usermetadata, tuser_segment_info},
              {1'b0, exp_q[0]});
      tr_mode = 0;
      drain();
      chk("drop_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

      // result FIFO overflow: 17 results, no packets yet
      for (int i = 0; i < 17; i++) begin
         issue_res(EGR_PORT_W'(i), 1'b0);
         if (i == 14) chk("ovf_full_after15", 64'(res_fifo_full), 64'd0);
         if (i == 15) begin
            chk("ovf_full_after16", 64'(res_fifo_full), 64'd1);
            chk("ovf_flag_after16", 64'(res_overflow), 64'd0);
         end
      end
      chk("ovf_flag_after17", 64'(res_overflow), 64'd1);
      tr_mode = 2; gap_en = 1;
      for (int i = 0; i < 16; i++)
         push_pkt(EGR_PORT_W'(i), 1'b0, $urandom_range(1, 3), $urandom_range(1, 64), -1, 1'b0);
      drain();
      chk("ovf_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));
      chk("ovf_full_cleared", 64'(res_fifo_full), 64'd0);

      // protocol error: sop on beat 2 of 4
      chk("perr_before", 64'(proto_err), 64'd0);
      push_pkt(4'd12, 1'b0, 4, 41, 2, 1'b1);
      drain();
      chk("perr_after", 64'(proto_err), 64'd1);
      chk("perr_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));

      // reset mid-packet
      tr_mode = 0; gap_en = 0;
      base = mon_cnt;
      push_pkt(4'd6, 1'b0, 4, 64, -1, 1'b1);
      k = 0;
      while (mon_cnt - base < 2 && k < 50) begin
         tick();
         k++;
      end
      chk("mid_pkt_reached", 64'(k < 50), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_tvalid", 64'(tvalid), 64'd0);
      chk("arst_fwd_cnt", 64'(pkt_fwd_cnt), 64'd0);
      chk("arst_drop_cnt", 64'(pkt_drop_cnt), 64'd0);
      chk("arst_state_idle", 64'(dbg_state), 64'd0);
      chk("arst_no_pop", 64'(aln_fifo_pop), 64'd0);
      chk("arst_flags", {61'd0, res_overflow, proto_err, res_fifo_full}, 64'd0);
      aln_q.delete();
      exp_q.delete();
      exp_fwd = 0;
      exp_drop = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_pkt(4'd2, 1'b0, 3, 5, -1, 1'b1);
      drain();
      chk("post_rst_fwd_cnt", 64'(pkt_fwd_cnt), 64'd1);

      // randomized batches
      tr_mode = 2; gap_en = 1;
      for (int b = 0; b < 6; b++) begin
         for (int p = 0; p < 5; p++)
            push_pkt(EGR_PORT_W'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3),
                     $urandom_range(1, 5), $urandom_range(1, 64), -1, 1'b1);
         drain();
      end
      chk("rand_fwd_cnt", 64'(pkt_fwd_cnt), 64'(exp_fwd));
      chk("rand_drop_cnt", 64'(pkt_drop_cnt), 64'(exp_drop));
      chk("rand_no_perr", 64'(proto_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/parse_class_egr_intf.md
# parse_class_egr_intf

Egress stage of the parse/classify path. It pairs each per-packet classification result from the l2l3l4 classifier with the packet beats held in the align FIFO of the ingress interface, and pops those beats. Forwarded packets leave on an AXI-S master with `egr_port` overwritten and `tkeep` rebuilt from `bytesvld`. Dropped packets are drained silently.

## Interface
Parameters:
- `TDATA_WIDTH`, 512: data bus width in bits.
- `USERMETADATA_WIDTH`, 1: width of the user-metadata sideband.
- `SEGMENT_WIDTH`, 128: segment width in bits.
- `SEGMENT_DEPTH`, `TDATA_WIDTH/SEGMENT_WIDTH`: segments per beat.
- `RES_FIFO_DEPTH`, 16: number of result FIFO entries; power of 2.
- `CNT_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `res_vld` in 1: classification result strobe; one per packet, in packet order.
- `res_egr_port` in `$bits(SEGMENT_INFO_S.egr_port)`: egress port for the packet.
- `res_drop` in 1: drop the packet.
- `res_fifo_full` out 1: result FIFO is full.
- `aln_fifo_tdata` in `[SEGMENT_DEPTH-1:0][SEGMENT_WIDTH-1:0]`: align FIFO head, show-ahead; valid while `!aln_fifo_empty`.
- `aln_fifo_tuser_usermetadata` in `USERMETADATA_WIDTH`: align FIFO head metadata.
- `aln_fifo_tuser_segment_info` in `packet_switch_pkg::SEGMENT_INFO_S`: align FIFO head segment info.
- `aln_fifo_empty` in 1: align FIFO is empty.
- `aln_fifo_pop` out 1: advance the align FIFO head.
- `tvalid` out 1: AXI-S valid.
- `tready` in 1: AXI-S ready.
- `tdata` out `[SEGMENT_DEPTH-1:0][SEGMENT_WIDTH-1:0]`: AXI-S data.
- `tkeep` out `TDATA_WIDTH/8`: AXI-S byte enables.
- `tuser_usermetadata` out `USERMETADATA_WIDTH`: user metadata.
- `tuser_segment_info` out `SEGMENT_INFO_S`: segment info.
- `pkt_fwd_cnt` out `CNT_WIDTH`: forwarded-packet count.
- `pkt_drop_cnt` out `CNT_WIDTH`: dropped-packet count.
- `res_overflow` out 1: sticky; a result was written while the FIFO was full.
- `proto_err` out 1: sticky; `sop` seen mid-packet.

## Operation
Result FIFO:
- Internal, `RES_FIFO_DEPTH` entries.
- Each entry is {`egr_port`, `drop`}, written on `res_vld`.
- A write while full is discarded and sets `res_overflow`.

FSM states: IDLE, FWD, DROP.
- **IDLE**: when the result FIFO is non-empty and `!aln_fifo_empty`, pop one result and latch `cur_egr_port` and `cur_drop`.
  - Go to DROP if `cur_drop`, else to FWD.
  - No align pop occurs in IDLE.
- **FWD**: `aln_fifo_pop = !aln_fifo_empty & (!tvalid | tready)`.
  - A popped beat loads the output register: tdata, usermetadata, and segment_info with `egr_port=cur_egr_port`.
  - `tkeep` = all ones if `bytesvld==64`, else `(1<<bytesvld)-1`.
  - On a popped beat with `eop`: increment `pkt_fwd_cnt` and go to IDLE.
- **DROP**: `aln_fifo_pop = !aln_fifo_empty`, independent of `tready`; the output register is untouched.
  - On a popped `eop`: increment `pkt_drop_cnt` and go to IDLE.
- A popped beat with `sop` that is not the first beat of the current packet sets `proto_err`. It is otherwise treated as a continuation beat.

Output register, AXI rules:
- While `tvalid & !tready`, all outputs are held stable.
- `tvalid` clears on `tready` when no new beat is loaded.

Counters wrap modulo 2^`CNT_WIDTH`.

Reset (`rst_n` low, asynchronous, takes effect at any point including mid-packet):
- state = IDLE; result FIFO empty.
- `tvalid`=0; `tdata`, `tkeep`, tuser outputs = 0.
- Counters = 0; `res_overflow` = 0; `proto_err` = 0.
- `aln_fifo_pop`=0 while in reset.
- The upstream align FIFO is reset in the same reset event; no resynchronisation is done here.

## Timing
- `res_vld` at cycle N → result visible to the FSM at N+1 → IDLE pops the result at N+1 → FWD at N+2 with first align pop → `tvalid` at N+3, provided the align FIFO is non-empty.
- FWD throughput: 1 beat/cycle while `tready` is high.
- One idle cycle between packets, for the IDLE result pop.
- DROP drains 1 beat/cycle.
- `aln_fifo_pop` is combinational from state, `aln_fifo_empty`, `tvalid`, and `tready`. There are no other combinational input-to-output paths.
- `res_fifo_full` is registered and reflects occupancy after the previous cycle's write/pop.
- Simultaneous result write and pop on a full FIFO: the write is accepted (the pop frees the slot); no overflow is flagged.

## Test plan
- **Single-beat forward.** Result {egr_port=3, drop=0}; one beat with sop=eop=1, bytesvld=60. Expected: `tvalid` at N+3; `egr_port`=3; `tkeep`=`64'h0FFF_FFFF_FFFF_FFFF`; `pkt_fwd_cnt`=1.
- **Back-to-back 4-beat packets under backpressure.** Two 4-beat packets; `tready` toggles 1,0,1,0. Expected: no beat lost or duplicated; data held stable while stalled; `sop`/`eop` ordering preserved; `pkt_fwd_cnt`=2.
- **Drop with `tready`=0.** Result drop=1 for a 3-beat packet, then a forward packet, with `tready` held 0. Expected: 3 pops occur with no `tvalid`; `pkt_drop_cnt`=1; the second packet waits at the output.
- **Result overflow.** 17 results written with `RES_FIFO_DEPTH`=16 and no packets. Expected: `res_fifo_full`=1 after the 16th; `res_overflow`=1; 16 packets subsequently forward.
- **Protocol error.** Mid-packet beat with `sop`=1. Expected: `proto_err`=1; packet completes on `eop`; `pkt_fwd_cnt` increments by 1.
- **Reset mid-packet.** `rst_n` asserted after beat 2 of 4. Expected: `tvalid`=0 immediately (asynchronous); counters=0; FSM in IDLE; clean forward of the next packet after release.
